iomem_interconnect: RTL and testbench

- Single-master, N-slave controller for the picosoc iomem peripheral bus.
- Sits between the soc iomem port and the GPIO/audio/video/I2C peripherals, replacing the ad-hoc ready/rdata glue in top.
- Decodes addr[31:24], drives exactly one slave valid, and sequences the handshake through a small FSM.
- Returns registered read data with per-slave selection (not ready-based), and terminates unmapped or hung accesses via a timeout watchdog with error reporting.

---
 rtl/iomem_pkg.sv | 22 ++
 rtl/iomem_addr_decode.sv | 26 ++
 rtl/iomem_interconnect.sv | 186 ++++++++++++++++++
 tb/tb_iomem_interconnect.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// Shared types and constants for the picosoc iomem interconnect:
// FSM encoding, the error read-data pattern and the region IDs of the peripherals.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_ERROR   = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [7:0] ID_GPIO  = 8'h03;
  localparam logic [7:0] ID_AUDIO = 8'h04;
  localparam logic [7:0] ID_VIDEO = 8'h05;
  localparam logic [7:0] ID_I2C   = 8'h07;

  // Slot i holds the region ID of slave i, slot 0 in the low byte.
  localparam logic [31:0] DEFAULT_SLAVE_IDS = {ID_I2C, ID_VIDEO, ID_AUDIO, ID_GPIO};

endpackage

// File: rtl/iomem_addr_decode.sv
// Region decoder: matches addr[31:24] against the per-slot IDs and returns
// a one-hot select (lowest matching slot wins) plus a hit flag.
module iomem_addr_decode
  import iomem_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [8*NUM_SLAVES-1:0]   SLAVE_IDS  = DEFAULT_SLAVE_IDS
) (
  input  logic [7:0]            region,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  logic [NUM_SLAVES-1:0] match_s;

  // Raw per-slot comparison, then isolate the lowest set bit so duplicates stay one-hot.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      match_s[i] = (region == SLAVE_IDS[8*i +: 8]);
    end
    sel = match_s & (~match_s + NUM_SLAVES'(1));
    hit = |match_s;
  end

endmodule

// File: rtl/iomem_interconnect.sv
// Single-master, N-slave iomem controller: decodes the region, sequences the
// slave handshake and terminates unmapped or hung accesses with an error response.
module iomem_interconnect
  import iomem_pkg::*;
#(
  parameter int                        NUM_SLAVES     = 4,
  parameter logic [8*NUM_SLAVES-1:0]   SLAVE_IDS      = DEFAULT_SLAVE_IDS,
  parameter int                        TIMEOUT_W      = 8,
  parameter logic [TIMEOUT_W-1:0]      TIMEOUT_CYCLES = 8'd200,
  parameter logic [31:0]               ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [31:0]              m_addr,
  input  logic [3:0]               m_wstrb,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [31:0]              s_addr,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_wdata,
  output logic                     err_irq,
  output logic                     err_flag,
  output logic [31:0]              err_addr,
  input  logic                     err_clear
);

  if (TIMEOUT_CYCLES == '0) begin : g_bad_timeout
    $error("iomem_interconnect: TIMEOUT_CYCLES must be non-zero");
  end

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   s_valid_q, s_valid_d;
  logic [31:0]             s_addr_q, s_addr_d;
  logic [3:0]              s_wstrb_q, s_wstrb_d;
  logic [31:0]             s_wdata_q, s_wdata_d;
  logic                    m_ready_q, m_ready_d;
  logic [31:0]             m_rdata_q, m_rdata_d;
  logic                    err_irq_q, err_irq_d;
  logic                    err_flag_q, err_flag_d;
  logic [31:0]             err_addr_q, err_addr_d;
  logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0]   dec_sel_s;
  logic                    dec_hit_s;
  logic                    sel_ready_s;
  logic [31:0]             sel_rdata_s;

  iomem_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_IDS  (SLAVE_IDS)
  ) u_decode (
    .region (m_addr[31:24]),
    .sel    (dec_sel_s),
    .hit    (dec_hit_s)
  );

  // Ready and read data come only from the slave currently being driven.
  always_comb begin
    sel_ready_s = |(s_ready & s_valid_q);
    sel_rdata_s = 32'h0000_0000;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_rdata_s = sel_rdata_s | (s_rdata[32*i +: 32] & {32{s_valid_q[i]}});
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d    = state_q;
    s_valid_d  = s_valid_q;
    s_addr_d   = s_addr_q;
    s_wstrb_d  = s_wstrb_q;
    s_wdata_d  = s_wdata_q;
    m_ready_d  = 1'b0;
    m_rdata_d  = m_rdata_q;
    err_irq_d  = 1'b0;
    err_addr_d = err_addr_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          s_addr_d  = m_addr;
          s_wstrb_d = m_wstrb;
          s_wdata_d = m_wdata;
          cnt_d     = '0;
          if (dec_hit_s) begin
            s_valid_d = dec_sel_s;
            state_d   = ST_ACCESS;
          end else begin
            s_valid_d  = '0;
            m_rdata_d  = ERR_RDATA;
            err_irq_d  = 1'b1;
            err_addr_d = m_addr;
            state_d    = ST_ERROR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A ready on the last allowed cycle still wins over the watchdog.
        if (sel_ready_s) begin
          m_rdata_d = (s_wstrb_q != 4'b0000) ? 32'h0000_0000 : sel_rdata_s;
          s_valid_d = '0;
          m_ready_d = 1'b1;
          state_d   = ST_RESPOND;
        end else if (cnt_q == TO_LAST) begin
          s_valid_d  = '0;
          m_rdata_d  = ERR_RDATA;
          err_irq_d  = 1'b1;
          err_addr_d = s_addr_q;
          state_d    = ST_ERROR;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + TIMEOUT_W'(1);
        end
      end
      ST_ERROR: begin
        m_ready_d = 1'b1;
        state_d   = ST_RESPOND;
      end
      ST_RESPOND: begin
        state_d = ST_IDLE;
      end
      default: begin
        s_valid_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    if (err_irq_d) begin
      err_flag_d = 1'b1;
    end else if (err_clear) begin
      err_flag_d = 1'b0;
    end else begin
      err_flag_d = err_flag_q;
    end
  end

  // State and output registers; reset aborts any transaction without a response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      s_valid_q  <= '0;
      s_addr_q   <= 32'h0000_0000;
      s_wstrb_q  <= 4'b0000;
      s_wdata_q  <= 32'h0000_0000;
      m_ready_q  <= 1'b0;
      m_rdata_q  <= 32'h0000_0000;
      err_irq_q  <= 1'b0;
      err_flag_q <= 1'b0;
      err_addr_q <= 32'h0000_0000;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      s_valid_q  <= s_valid_d;
      s_addr_q   <= s_addr_d;
      s_wstrb_q  <= s_wstrb_d;
      s_wdata_q  <= s_wdata_d;
      m_ready_q  <= m_ready_d;
      m_rdata_q  <= m_rdata_d;
      err_irq_q  <= err_irq_d;
      err_flag_q <= err_flag_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign s_valid  = s_valid_q;
  assign s_addr   = s_addr_q;
  assign s_wstrb  = s_wstrb_q;
  assign s_wdata  = s_wdata_q;
  assign m_ready  = m_ready_q;
  assign m_rdata  = m_rdata_q;
  assign err_irq  = err_irq_q;
  assign err_flag = err_flag_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_iomem_interconnect.sv
// Directed self-checking bench for iomem_interconnect: one task per scenario,
// inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_iomem_interconnect;

  logic         clk = 1'b0;
  logic         resetn;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_addr;
  logic [3:0]   m_wstrb;
  logic [31:0]  m_wdata;
  logic [31:0]  m_rdata;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;
  logic [31:0]  s_addr;
  logic [3:0]   s_wstrb;
  logic [31:0]  s_wdata;
  logic         err_irq;
  logic         err_flag;
  logic [31:0]  err_addr;
  logic         err_clear;

  int checks = 0;
  int errors = 0;

  iomem_interconnect dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_wstrb   (m_wstrb),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .s_addr    (s_addr),
    .s_wstrb   (s_wstrb),
    .s_wdata   (s_wdata),
    .err_irq   (err_irq),
    .err_flag  (err_flag),
    .err_addr  (err_addr),
    .err_clear (err_clear)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Starts a request at the beginning of a fresh cycle (cycle 0).
  task automatic issue(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
    next_cycle();
    m_addr  = a;
    m_wstrb = ws;
    m_wdata = wd;
    m_valid = 1'b1;
  endtask

  task automatic finish_req();
    next_cycle();
    m_valid = 1'b0;
    s_ready = 4'b0000;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    m_valid = 1'b0; m_addr = 32'h0; m_wstrb = 4'h0; m_wdata = 32'h0;
    s_ready = 4'b0000; s_rdata = 128'h0; err_clear = 1'b0;
    #1 resetn = 1'b0;
    #2;
    checks++; if (s_valid !== 4'b0000) begin errors++; $display("FAIL rst_svalid: got %b want 0000", s_valid); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rst_mready: got %b want 0", m_ready); end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL rst_mrdata: got %h want 0", m_rdata); end
    checks++; if ({err_irq, err_flag} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", {err_irq, err_flag}); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL rst_erraddr: got %h want 0", err_addr); end
    checks++; if ({s_addr, s_wstrb, s_wdata} !== 68'h0) begin errors++; $display("FAIL rst_sreq: got %h want 0", {s_addr, s_wstrb, s_wdata}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_read_gpio();
    issue(32'h0300_0004, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (s_valid !== 4'b0000) begin errors++; $display("FAIL rd_c0_svalid: got %b want 0000", s_valid); end
    next_cycle();
    s_ready = 4'b0001;
    s_rdata[31:0] = 32'h0000_00A5;
    @(negedge clk);
    checks++; if (s_valid !== 4'b0001) begin errors++; $display("FAIL rd_c1_svalid: got %b want 0001", s_valid); end
    checks++; if (s_addr !== 32'h0300_0004) begin errors++; $display("FAIL rd_c1_saddr: got %h want 03000004", s_addr); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rd_c1_mready: got %b want 0", m_ready); end
    next_cycle();
    s_ready = 4'b0000;
    @(negedge clk);
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL rd_c2_mready: got %b want 1", m_ready); end
    checks++; if (m_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL rd_c2_mrdata: got %h want 000000a5", m_rdata); end
    checks++; if (s_valid !== 4'b0000) begin errors++; $display("FAIL rd_c2_svalid: got %b want 0000", s_valid); end
    finish_req();
    @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rd_c3_mready: got %b want 0", m_ready); end
  endtask

  task automatic test_write_video();
    issue(32'h0500_0010, 4'hF, 32'h1234_5678);
    s_rdata[95:64] = 32'hFFFF_FFFF;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      s_ready = (c == 4) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (c <= 4) begin
        checks++; if (s_valid !== 4'b0100) begin errors++; $display("FAIL wr_c%0d_svalid: got %b want 0100", c, s_valid); end
        checks++; if (s_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_c%0d_swdata: got %h want 12345678", c, s_wdata); end
      end
      checks++; if (m_ready !== (c == 5)) begin errors++; $display("FAIL wr_c%0d_mready: got %b want %b", c, m_ready, (c == 5)); end
    end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL wr_mrdata: got %h want 0", m_rdata); end
    finish_req();
  endtask

  task automatic test_unmapped();
    issue(32'h0600_0000, 4'h0, 32'h0);
    next_cycle();
    @(negedge clk);
    checks++; if (s_valid !== 4'b0000) begin errors++; $display("FAIL um_c1_svalid: got %b want 0000", s_valid); end
    checks++; if (err_irq !== 1'b1) begin errors++; $display("FAIL um_c1_irq: got %b want 1", err_irq); end
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL um_c1_mready: got %b want 0", m_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL um_c2_mready: got %b want 1", m_ready); end
    checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL um_c2_mrdata: got %h want deadbeef", m_rdata); end
    checks++; if (err_irq !== 1'b0) begin errors++; $display("FAIL um_c2_irq: got %b want 0", err_irq); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL um_c2_flag: got %b want 1", err_flag); end
    checks++; if (err_addr !== 32'h0600_0000) begin errors++; $display("FAIL um_c2_erraddr: got %h want 06000000", err_addr); end
    finish_req();
  endtask

  task automatic test_err_clear();
    next_cycle();
    err_clear = 1'b1;
    next_cycle();
    err_clear = 1'b0;
    @(negedge clk);
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL clr_flag: got %b want 0", err_flag); end
    checks++; if (err_addr !== 32'h0600_0000) begin errors++; $display("FAIL clr_erraddr: got %h want 06000000", err_addr); end
  endtask

  // Non-selected slaves are held ready the whole time and must be ignored.
  task automatic test_timeout();
    int sv_cnt, bad_sv, rc, ic;
    logic [31:0] rd;
    sv_cnt = 0; bad_sv = 0; rc = -1; ic = -1; rd = 32'h0;
    issue(32'h0700_0000, 4'h0, 32'h0);
    s_ready = 4'b0111;
    for (int c = 1; c <= 230 && rc < 0; c++) begin
      next_cycle();
      @(negedge clk);
      if (s_valid == 4'b1000) sv_cnt++;
      else if (s_valid != 4'b0000) bad_sv++;
      if (err_irq && ic < 0) ic = c;
      if (m_ready) begin rc = c; rd = m_rdata; end
    end
    checks++; if (sv_cnt !== 200) begin errors++; $display("FAIL to_svalid_cycles: got %0d want 200", sv_cnt); end
    checks++; if (bad_sv !== 0) begin errors++; $display("FAIL to_other_svalid: got %0d want 0", bad_sv); end
    checks++; if (rc !== 202) begin errors++; $display("FAIL to_mready_cycle: got %0d want 202", rc); end
    checks++; if (ic !== 201) begin errors++; $display("FAIL to_irq_cycle: got %0d want 201", ic); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_mrdata: got %h want deadbeef", rd); end
    checks++; if (err_addr !== 32'h0700_0000) begin errors++; $display("FAIL to_erraddr: got %h want 07000000", err_addr); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", err_flag); end
    finish_req();
  endtask

  task automatic test_last_cycle_ready();
    int rc, irq_seen;
    logic [31:0] rd;
    rc = -1; irq_seen = 0; rd = 32'h0;
    issue(32'h0700_0000, 4'h0, 32'h0);
    err_clear = 1'b1;
    s_rdata[127:96] = 32'h7777_0001;
    for (int c = 1; c <= 230 && rc < 0; c++) begin
      next_cycle();
      err_clear = 1'b0;
      s_ready = (c == 200) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (err_irq) irq_seen++;
      if (m_ready) begin rc = c; rd = m_rdata; end
    end
    checks++; if (rc !== 201) begin errors++; $display("FAIL lc_mready_cycle: got %0d want 201", rc); end
    checks++; if (rd !== 32'h7777_0001) begin errors++; $display("FAIL lc_mrdata: got %h want 77770001", rd); end
    checks++; if (irq_seen !== 0) begin errors++; $display("FAIL lc_irq: got %0d pulses want 0", irq_seen); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL lc_flag: got %b want 0", err_flag); end
    finish_req();
  endtask

  task automatic test_clear_vs_error();
    issue(32'h0800_0000, 4'h0, 32'h0);
    err_clear = 1'b1;
    next_cycle();
    err_clear = 1'b0;
    @(negedge clk);
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL cve_flag: got %b want 1", err_flag); end
    checks++; if (err_irq !== 1'b1) begin errors++; $display("FAIL cve_irq: got %b want 1", err_irq); end
    next_cycle();
    @(negedge clk);
    checks++; if (err_addr !== 32'h0800_0000) begin errors++; $display("FAIL cve_erraddr: got %h want 08000000", err_addr); end
    checks++; if (m_ready !== 1'b1) begin errors++; $display("FAIL cve_mready: got %b want 1", m_ready); end
    finish_req();
  endtask

  task automatic test_back_to_back();
    issue(32'h0300_0000, 4'h0, 32'h0);
    s_ready = 4'b0011;
    s_rdata[31:0]  = 32'h0000_0011;
    s_rdata[63:32] = 32'h0000_0022;
    next_cycle();
    @(negedge clk);
    checks++; if (s_valid !== 4'b0001) begin errors++; $display("FAIL b2b_c1_svalid: got %b want 0001", s_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if ({m_ready, m_rdata} !== {1'b1, 32'h0000_0011}) begin errors++; $display("FAIL b2b_c2_resp: got %b/%h want 1/00000011", m_ready, m_rdata); end
    next_cycle();
    m_addr = 32'h0400_0008;
    @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL b2b_c3_mready: got %b want 0", m_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (s_valid !== 4'b0010) begin errors++; $display("FAIL b2b_c4_svalid: got %b want 0010", s_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if ({m_ready, m_rdata} !== {1'b1, 32'h0000_0022}) begin errors++; $display("FAIL b2b_c5_resp: got %b/%h want 1/00000022", m_ready, m_rdata); end
    finish_req();
  endtask

  task automatic test_reset_mid_access();
    issue(32'h0700_0000, 4'h0, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (s_valid !== 4'b1000) begin errors++; $display("FAIL rma_pre_svalid: got %b want 1000", s_valid); end
    #2 resetn = 1'b0;
    m_valid = 1'b0;
    #1;
    checks++; if (s_valid !== 4'b0000) begin errors++; $display("FAIL rma_svalid: got %b want 0000", s_valid); end
    checks++; if ({m_ready, m_rdata, s_addr} !== 65'h0) begin errors++; $display("FAIL rma_outs: got %b/%h/%h want 0", m_ready, m_rdata, s_addr); end
    checks++; if ({err_flag, err_addr} !== 33'h0) begin errors++; $display("FAIL rma_err: got %b/%h want 0", err_flag, err_addr); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rma_no_resp: got %b want 0", m_ready); end
    resetn = 1'b1;
    issue(32'h0300_0000, 4'h0, 32'h0);
    s_ready = 4'b0001;
    s_rdata[31:0] = 32'h0000_005A;
    next_cycle();
    @(negedge clk);
    checks++; if (s_valid !== 4'b0001) begin errors++; $display("FAIL rma_post_svalid: got %b want 0001", s_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if ({m_ready, m_rdata} !== {1'b1, 32'h0000_005A}) begin errors++; $display("FAIL rma_post_resp: got %b/%h want 1/0000005a", m_ready, m_rdata); end
    finish_req();
  endtask

  initial begin
    test_reset();
    test_read_gpio();
    test_write_video();
    test_unmapped();
    test_err_clear();
    test_timeout();
    test_last_cycle_ready();
    test_clear_vs_error();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end

endmodule
